ula_seq: RTL and testbench
==========================

Name: ula_seq

Overview:
- Command sequencer that drives the 8-bit ALU (ula) from the initiator side.
- Accepts one operation per valid/ready handshake and presents a, b and op to the ALU.
- Waits the ALU's registered latency, captures s and flag, and returns them on a result valid/ready handshake.
- Supports operand chaining (previous result becomes operand a) and counts completed operations. Sits between a host/control FSM and ula.

Parameters:
- ULA_LAT, 1, ALU latency in clk edges from operand change to valid s/flag (0 = combinational ALU).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  3  ALU opcode.
- cmd_a  input  8  operand a.
- cmd_b  input  8  operand b.
- cmd_chain  input  1  1 = use last captured result as operand a, ignoring cmd_a.
- ula_a  output  8  operand a to ALU.
- ula_b  output  8  operand b to ALU.
- ula_op  output  3  opcode to ALU.
- ula_s  input  8  ALU result.
- ula_flag  input  1  ALU flag.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_s  output  8  captured result.
- res_flag  output  1  captured flag.
- busy  output  1  high in any state except IDLE.
- op_count  output  CNT_W  number of completed result handshakes.

Behaviour:
- Reset (async, rst=1): state IDLE. ula_a, ula_b, ula_op, res_s, res_flag, op_count and last_res all clear to 0. res_valid=0, busy=0. cmd_ready=1 once rst deasserts.
- States: IDLE, WAIT, HOLD.
- cmd_ready = (state==IDLE), combinational from state only. It must not depend on cmd_valid.
- IDLE: on the edge with cmd_valid & cmd_ready:
  - ula_a <= cmd_chain ? last_res : cmd_a; ula_b <= cmd_b; ula_op <= cmd_op (all registered).
  - wcnt <= ULA_LAT; go to WAIT.
  - If cmd_valid=0, the state holds.
- WAIT: if wcnt==0, capture res_s<=ula_s, res_flag<=ula_flag, last_res<=ula_s, set res_valid<=1 and go to HOLD. Otherwise decrement wcnt.
- Latency: res_valid rises ULA_LAT+1 edges after the accepting edge (2 edges for the default).
- ula_a/b/op hold their values from the accept edge until the next accept. They never change while in WAIT or HOLD.
- HOLD: res_valid=1, and res_s/res_flag are stable until the handshake.
  - On the edge with res_valid & res_ready: res_valid<=0, op_count<=op_count+1 (wraps modulo 2^CNT_W), go to IDLE.
  - res_ready outside HOLD is ignored.
- Throughput: one operation per ULA_LAT+3 edges minimum. A new command is accepted the cycle after the result handshake, never the same cycle.
- Chaining: last_res updates only at capture, not at the handshake. cmd_chain with no prior result since reset uses 0.
- cmd_valid while not ready: command fields are ignored. The initiator must hold them until cmd_ready.
- Reset mid-operation (WAIT or HOLD): the in-flight result is discarded, res_valid drops asynchronously, and op_count clears.
- Opcodes pass through unmodified. The block does not interpret op.
- busy = (state!=IDLE).
- No combinational path from ula_s/ula_flag to any output.

Test Plan:
- Basic op: the bench ALU model registers s=a+b, flag=carry on clk (ULA_LAT=1). Send op=001, a=0x00, b=0x04 → ula_a=0x00, ula_b=0x04, ula_op=001 after the accept edge. res_valid rises 2 edges later with res_s=0x04, res_flag=0. op_count=1 after the handshake.
- Carry/back-pressure: a=0xFF, b=0x02, res_ready held 0 for 5 cycles → res_valid stays 1 with res_s=0x01, res_flag=1 throughout. cmd_ready stays 0 and a second cmd_valid is not accepted. After res_ready=1, state returns to IDLE and op_count increments once.
- Chain: a=0x10, b=0x05, then cmd_chain=1 with cmd_a=0xAA, b=0x03 → second ula_a=0x15 (not 0xAA), res_s=0x18.
- Latency parameter: ULA_LAT=0 with a combinational model, then ULA_LAT=3 with a 3-stage model → res_valid rises exactly 1 and 4 edges after accept respectively, with correct res_s.
- Reset mid-op: assert rst while in WAIT, and separately while in HOLD → res_valid=0 and op_count=0 immediately, cmd_ready=1 after release, and the next chained command uses a=0.
- Counter wrap: CNT_W=4, 17 completed ops → op_count=1.

Source files
------------

// File: rtl/ula_seq.sv
// ula_seq: command sequencer in front of the 8-bit ALU (ula).
// Takes one command per valid/ready handshake, drives the ALU operand
// registers, waits out the ALU latency, captures s/flag and returns them
// on a result valid/ready handshake. Supports chaining the last captured
// result into operand a and counts completed result handshakes.
module ula_seq #(
  parameter int ULA_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic             cmd_chain,
  output logic [7:0]       ula_a,
  output logic [7:0]       ula_b,
  output logic [2:0]       ula_op,
  input  logic [7:0]       ula_s,
  input  logic             ula_flag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_s,
  output logic             res_flag,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  // Wait counter must hold ULA_LAT; keep at least one bit for ULA_LAT of 0/1.
  localparam int WCW = (ULA_LAT < 2) ? 1 : $clog2(ULA_LAT + 1);

  state_t         state, state_nxt;
  logic [WCW-1:0] wcnt;
  logic [7:0]     last_res;
  logic           accept, capture, retire;

  // Ready/busy/valid come straight from the state register so no input
  // (in particular cmd_valid, ula_s, ula_flag) reaches them combinationally.
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = (state == HOLD);

  assign accept  = cmd_valid && (state == IDLE);
  assign capture = (state == WAIT) && (wcnt == '0);
  assign retire  = (state == HOLD) && res_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = WAIT;
      WAIT:    if (capture) state_nxt = HOLD;
      HOLD:    if (retire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU operand registers: loaded only on accept, frozen through WAIT/HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ula_a  <= '0;
      ula_b  <= '0;
      ula_op <= '0;
    end else if (accept) begin
      ula_a  <= cmd_chain ? last_res : cmd_a;
      ula_b  <= cmd_b;
      ula_op <= cmd_op;
    end
  end

  // Latency counter: loaded with ULA_LAT on accept, counts down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              wcnt <= '0;
    else if (accept)                      wcnt <= WCW'(ULA_LAT);
    else if (state == WAIT && wcnt != '0) wcnt <= wcnt - WCW'(1);
  end

  // Result capture; last_res follows capture, not the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_s    <= '0;
      res_flag <= 1'b0;
      last_res <= '0;
    end else if (capture) begin
      res_s    <= ula_s;
      res_flag <= ula_flag;
      last_res <= ula_s;
    end
  end

  // Completed-operation counter, wraps modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         op_count <= '0;
    else if (retire) op_count <= op_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq. Four instances:
// d=0 default (ULA_LAT=1), d=1 ULA_LAT=0, d=2 ULA_LAT=3, d=3 CNT_W=4.
// Each has an adder ALU model (s=a+b, flag=carry) with matching latency.
module tb_ula_seq;

  localparam int LATS [4] = '{1, 0, 3, 1};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid [4];
  logic       cmd_ready [4];
  logic [2:0] cmd_op    [4];
  logic [7:0] cmd_a     [4];
  logic [7:0] cmd_b     [4];
  logic       cmd_chain [4];
  logic [7:0] ula_a     [4];
  logic [7:0] ula_b     [4];
  logic [2:0] ula_op    [4];
  logic [7:0] ula_s     [4];
  logic       ula_flag  [4];
  logic       res_valid [4];
  logic       res_ready [4];
  logic [7:0] res_s     [4];
  logic       res_flag  [4];
  logic       busy      [4];
  logic [15:0] opc      [3];
  logic [3:0]  opc_w;

  int nchk = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  ula_seq #(.ULA_LAT(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_chain(cmd_chain[0]),
    .ula_a(ula_a[0]), .ula_b(ula_b[0]), .ula_op(ula_op[0]), .ula_s(ula_s[0]),
    .ula_flag(ula_flag[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_s(res_s[0]), .res_flag(res_flag[0]), .busy(busy[0]), .op_count(opc[0]));

  ula_seq #(.ULA_LAT(0), .CNT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_chain(cmd_chain[1]),
    .ula_a(ula_a[1]), .ula_b(ula_b[1]), .ula_op(ula_op[1]), .ula_s(ula_s[1]),
    .ula_flag(ula_flag[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_s(res_s[1]), .res_flag(res_flag[1]), .busy(busy[1]), .op_count(opc[1]));

  ula_seq #(.ULA_LAT(3), .CNT_W(16)) u_d2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
    .cmd_op(cmd_op[2]), .cmd_a(cmd_a[2]), .cmd_b(cmd_b[2]), .cmd_chain(cmd_chain[2]),
    .ula_a(ula_a[2]), .ula_b(ula_b[2]), .ula_op(ula_op[2]), .ula_s(ula_s[2]),
    .ula_flag(ula_flag[2]), .res_valid(res_valid[2]), .res_ready(res_ready[2]),
    .res_s(res_s[2]), .res_flag(res_flag[2]), .busy(busy[2]), .op_count(opc[2]));

  ula_seq #(.ULA_LAT(1), .CNT_W(4)) u_d3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[3]), .cmd_ready(cmd_ready[3]),
    .cmd_op(cmd_op[3]), .cmd_a(cmd_a[3]), .cmd_b(cmd_b[3]), .cmd_chain(cmd_chain[3]),
    .ula_a(ula_a[3]), .ula_b(ula_b[3]), .ula_op(ula_op[3]), .ula_s(ula_s[3]),
    .ula_flag(ula_flag[3]), .res_valid(res_valid[3]), .res_ready(res_ready[3]),
    .res_s(res_s[3]), .res_flag(res_flag[3]), .busy(busy[3]), .op_count(opc_w));

  // ALU models: 9-bit sum, delayed by LATS[g] clock stages.
  for (genvar g = 0; g < 4; g++) begin : g_alu
    localparam int L = LATS[g];
    logic [8:0] sum;
    assign sum = {1'b0, ula_a[g]} + {1'b0, ula_b[g]};
    if (L == 0) begin : g_comb
      assign {ula_flag[g], ula_s[g]} = sum;
    end else begin : g_pipe
      logic [8:0] pipe [L];
      always @(posedge clk) begin
        pipe[0] <= sum;
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
      assign {ula_flag[g], ula_s[g]} = pipe[L-1];
    end
  end

  // Drive a command and return 1ns after its accepting edge.
  task automatic issue(input int d, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic chain);
    int n;
    @(negedge clk);
    cmd_op[d] = op; cmd_a[d] = a; cmd_b[d] = b; cmd_chain[d] = chain;
    cmd_valid[d] = 1'b1;
    n = 0;
    while (cmd_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      nchk++; nfail++;
      $display("FAIL issue_timeout dut=%0d cmd_ready never rose", d);
    end
    @(posedge clk); #1;
    cmd_valid[d] = 1'b0;
  endtask

  // Count edges until res_valid is seen (sampled 1ns after each edge).
  task automatic wait_res(input int d, output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (res_valid[d] !== 1'b1 && edges < 20);
    if (edges >= 20) begin
      nchk++; nfail++;
      $display("FAIL res_timeout dut=%0d res_valid never rose", d);
    end
  endtask

  // Complete the result handshake; returns 1ns after the handshake edge.
  task automatic take(input int d);
    res_ready[d] = 1'b1;
    @(posedge clk); #1;
    res_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    nchk++; if (res_valid[0] !== 1'b0) begin nfail++; $display("FAIL rst_res_valid got %b exp 0", res_valid[0]); end
    nchk++; if (busy[0] !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", busy[0]); end
    nchk++; if (opc[0] !== 16'd0) begin nfail++; $display("FAIL rst_op_count got %0d exp 0", opc[0]); end
    nchk++; if (ula_a[0] !== 8'h00 || ula_b[0] !== 8'h00 || ula_op[0] !== 3'd0) begin nfail++; $display("FAIL rst_ula got %h %h %h exp 00 00 0", ula_a[0], ula_b[0], ula_op[0]); end
    nchk++; if (res_s[0] !== 8'h00 || res_flag[0] !== 1'b0) begin nfail++; $display("FAIL rst_res got %h %b exp 00 0", res_s[0], res_flag[0]); end
    @(negedge clk); rst = 1'b0; #1;
    nchk++; if (cmd_ready[0] !== 1'b1) begin nfail++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready[0]); end
  endtask

  task automatic test_basic();
    int e;
    issue(0, 3'b001, 8'h00, 8'h04, 1'b0);
    nchk++; if (ula_a[0] !== 8'h00 || ula_b[0] !== 8'h04 || ula_op[0] !== 3'b001) begin nfail++; $display("FAIL basic_ula got %h %h %b exp 00 04 001", ula_a[0], ula_b[0], ula_op[0]); end
    nchk++; if (cmd_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin nfail++; $display("FAIL basic_busy got rdy=%b busy=%b exp 0 1", cmd_ready[0], busy[0]); end
    wait_res(0, e);
    nchk++; if (e !== 2) begin nfail++; $display("FAIL basic_latency got %0d exp 2", e); end
    nchk++; if (res_s[0] !== 8'h04 || res_flag[0] !== 1'b0) begin nfail++; $display("FAIL basic_res got %h %b exp 04 0", res_s[0], res_flag[0]); end
    take(0);
    nchk++; if (opc[0] !== 16'd1 || cmd_ready[0] !== 1'b1) begin nfail++; $display("FAIL basic_done got cnt=%0d rdy=%b exp 1 1", opc[0], cmd_ready[0]); end
  endtask

  task automatic test_backpressure();
    int e;
    issue(0, 3'b010, 8'hFF, 8'h02, 1'b0);
    wait_res(0, e);
    cmd_op[0] = 3'b111; cmd_a[0] = 8'h33; cmd_b[0] = 8'h44; cmd_chain[0] = 1'b0;
    cmd_valid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      nchk++; if (res_valid[0] !== 1'b1 || res_s[0] !== 8'h01 || res_flag[0] !== 1'b1) begin nfail++; $display("FAIL bp_hold cyc=%0d got v=%b s=%h f=%b exp 1 01 1", i, res_valid[0], res_s[0], res_flag[0]); end
      nchk++; if (cmd_ready[0] !== 1'b0 || ula_a[0] !== 8'hFF || ula_op[0] !== 3'b010) begin nfail++; $display("FAIL bp_no_accept cyc=%0d got rdy=%b a=%h op=%b exp 0 ff 010", i, cmd_ready[0], ula_a[0], ula_op[0]); end
      @(posedge clk); #1;
    end
    cmd_valid[0] = 1'b0;
    take(0);
    nchk++; if (opc[0] !== 16'd2 || busy[0] !== 1'b0) begin nfail++; $display("FAIL bp_done got cnt=%0d busy=%b exp 2 0", opc[0], busy[0]); end
  endtask

  task automatic test_chain();
    int e;
    issue(0, 3'b001, 8'h10, 8'h05, 1'b0);
    wait_res(0, e);
    take(0);
    issue(0, 3'b001, 8'hAA, 8'h03, 1'b1);
    nchk++; if (ula_a[0] !== 8'h15) begin nfail++; $display("FAIL chain_a got %h exp 15", ula_a[0]); end
    wait_res(0, e);
    nchk++; if (res_s[0] !== 8'h18) begin nfail++; $display("FAIL chain_res got %h exp 18", res_s[0]); end
    take(0);
    nchk++; if (opc[0] !== 16'd4) begin nfail++; $display("FAIL chain_cnt got %0d exp 4", opc[0]); end
  endtask

  task automatic test_back_to_back();
    int e;
    issue(0, 3'b011, 8'h20, 8'h01, 1'b0);
    wait_res(0, e);
    // Offer the next command in the same cycle as the result handshake.
    cmd_op[0] = 3'b100; cmd_a[0] = 8'h01; cmd_b[0] = 8'h01; cmd_chain[0] = 1'b0;
    cmd_valid[0] = 1'b1;
    res_ready[0] = 1'b1;
    @(posedge clk); #1;
    res_ready[0] = 1'b0;
    nchk++; if (busy[0] !== 1'b0 || ula_a[0] !== 8'h20) begin nfail++; $display("FAIL b2b_same_cycle got busy=%b a=%h exp 0 20", busy[0], ula_a[0]); end
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    nchk++; if (busy[0] !== 1'b1 || ula_a[0] !== 8'h01 || ula_op[0] !== 3'b100) begin nfail++; $display("FAIL b2b_next_cycle got busy=%b a=%h op=%b exp 1 01 100", busy[0], ula_a[0], ula_op[0]); end
    wait_res(0, e);
    nchk++; if (e !== 2 || res_s[0] !== 8'h02) begin nfail++; $display("FAIL b2b_res got lat=%0d s=%h exp 2 02", e, res_s[0]); end
    take(0);
    nchk++; if (opc[0] !== 16'd6) begin nfail++; $display("FAIL b2b_cnt got %0d exp 6", opc[0]); end
  endtask

  task automatic test_latency();
    int e;
    issue(1, 3'b000, 8'h03, 8'h04, 1'b0);
    wait_res(1, e);
    nchk++; if (e !== 1 || res_s[1] !== 8'h07 || res_flag[1] !== 1'b0) begin nfail++; $display("FAIL lat0 got lat=%0d s=%h f=%b exp 1 07 0", e, res_s[1], res_flag[1]); end
    take(1);
    issue(2, 3'b101, 8'h80, 8'h80, 1'b0);
    wait_res(2, e);
    nchk++; if (e !== 4 || res_s[2] !== 8'h00 || res_flag[2] !== 1'b1) begin nfail++; $display("FAIL lat3 got lat=%0d s=%h f=%b exp 4 00 1", e, res_s[2], res_flag[2]); end
    take(2);
    nchk++; if (opc[1] !== 16'd1 || opc[2] !== 16'd1) begin nfail++; $display("FAIL lat_cnt got %0d %0d exp 1 1", opc[1], opc[2]); end
  endtask

  task automatic test_reset_midop();
    int e;
    issue(0, 3'b001, 8'h07, 8'h07, 1'b0);
    rst = 1'b1; #1;
    nchk++; if (busy[0] !== 1'b0 || opc[0] !== 16'd0 || res_valid[0] !== 1'b0) begin nfail++; $display("FAIL rst_wait got busy=%b cnt=%0d v=%b exp 0 0 0", busy[0], opc[0], res_valid[0]); end
    @(negedge clk); rst = 1'b0; #1;
    nchk++; if (cmd_ready[0] !== 1'b1) begin nfail++; $display("FAIL rst_wait_ready got %b exp 1", cmd_ready[0]); end
    issue(0, 3'b001, 8'h07, 8'h07, 1'b0);
    wait_res(0, e);
    rst = 1'b1; #1;
    nchk++; if (res_valid[0] !== 1'b0 || opc[0] !== 16'd0 || res_s[0] !== 8'h00) begin nfail++; $display("FAIL rst_hold got v=%b cnt=%0d s=%h exp 0 0 00", res_valid[0], opc[0], res_s[0]); end
    @(negedge clk); rst = 1'b0; #1;
    nchk++; if (cmd_ready[0] !== 1'b1) begin nfail++; $display("FAIL rst_hold_ready got %b exp 1", cmd_ready[0]); end
    issue(0, 3'b001, 8'h55, 8'h09, 1'b1);
    nchk++; if (ula_a[0] !== 8'h00) begin nfail++; $display("FAIL rst_chain_a got %h exp 00", ula_a[0]); end
    wait_res(0, e);
    nchk++; if (res_s[0] !== 8'h09) begin nfail++; $display("FAIL rst_chain_res got %h exp 09", res_s[0]); end
    take(0);
    nchk++; if (opc[0] !== 16'd1) begin nfail++; $display("FAIL rst_chain_cnt got %0d exp 1", opc[0]); end
  endtask

  task automatic test_wrap();
    int e;
    for (int i = 0; i < 17; i++) begin
      issue(3, 3'b001, 8'(i), 8'h01, 1'b0);
      wait_res(3, e);
      take(3);
      if (i == 15) begin
        nchk++; if (opc_w !== 4'd0) begin nfail++; $display("FAIL wrap_16 got %0d exp 0", opc_w); end
      end
    end
    nchk++; if (opc_w !== 4'd1) begin nfail++; $display("FAIL wrap_17 got %0d exp 1", opc_w); end
    nchk++; if (res_s[3] !== 8'h11) begin nfail++; $display("FAIL wrap_res got %h exp 11", res_s[3]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      cmd_valid[i] = 1'b0; cmd_op[i] = '0; cmd_a[i] = '0; cmd_b[i] = '0;
      cmd_chain[i] = 1'b0; res_ready[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_backpressure();
    test_chain();
    test_back_to_back();
    test_latency();
    test_reset_midop();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
